stg_wb_mq: RTL and testbench

Multi-channel writeback merge stage for the amber core. It accepts general-purpose register writes from `N_CH` independent result producers, such as the ALU and the load/store unit, and queues each producer in its own FIFO. It then retires at most one write per cycle to the GP register-file write port, using round-robin arbitration. It also publishes a pending-write bitmask that the hazard unit uses to stall dependent reads.

---
 rtl/stg_wb_mq.sv | 135 +++++++++++++
 tb/tb_stg_wb_mq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stg_wb_mq.sv
// stg_wb_mq: per-producer writeback FIFOs merged round-robin onto one GP write port,
// with a pending-register mask for the hazard unit.
module stg_wb_mq #(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 24,
    parameter int GP_AW  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst_n,
    input  logic                     iw_flush,
    input  logic [N_CH-1:0]          iw_ch_valid,
    output logic [N_CH-1:0]          ow_ch_ready,
    input  logic [N_CH*GP_AW-1:0]    iw_ch_addr,
    input  logic [N_CH*DATA_W-1:0]   iw_ch_data,
    output logic                     ow_gp_write_enable,
    output logic [GP_AW-1:0]         ow_gp_write_addr,
    output logic [DATA_W-1:0]        ow_gp_write_data,
    output logic [(N_CH>1 ? $clog2(N_CH) : 1)-1:0] ow_gp_write_ch,
    output logic [(1<<GP_AW)-1:0]    ow_pending_mask,
    output logic [CNT_W-1:0]         ow_retire_count
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int PW = $clog2(DEPTH);

    logic [GP_AW-1:0]  fa [N_CH][DEPTH];
    logic [DATA_W-1:0] fd [N_CH][DEPTH];
    logic [PW:0]       wp [N_CH];
    logic [PW:0]       rp [N_CH];
    logic [PW:0]       occ [N_CH];
    logic [N_CH-1:0]   ne;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   push;
    logic [CW-1:0]     rr;
    logic [CW-1:0]     gnt;
    logic [CW-1:0]     nrr;
    logic              gnt_v;
    logic [GP_AW-1:0]  hd_a;
    logic [DATA_W-1:0] hd_d;
    logic [(1<<GP_AW)-1:0] pm;

    // Pointers carry one extra wrap bit, so occupancy == DEPTH shows up as its MSB.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            occ[k]  = wp[k] - rp[k];
            ne[k]   = wp[k] != rp[k];
            full[k] = occ[k][PW];
        end
    end

    assign ow_ch_ready = {N_CH{iw_rst_n & ~iw_flush}} & ~full;
    assign push        = iw_ch_valid & ow_ch_ready;

    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!gnt_v && ne[(int'(rr) + i) % N_CH]) begin
                gnt_v = 1'b1;
                gnt   = CW'((int'(rr) + i) % N_CH);
            end
        end
        nrr  = CW'((int'(gnt) + 1) % N_CH);
        hd_a = '0;
        hd_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt == CW'(k)) begin
                hd_a = fa[k][rp[k][PW-1:0]];
                hd_d = fd[k][rp[k][PW-1:0]];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pm = '0;
        for (int k = 0; k < N_CH; k++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ({1'b0, PW'(j) - rp[k][PW-1:0]} < occ[k])
                    pm[fa[k][j]] = 1'b1;
            end
        end
        if (ow_gp_write_enable)
            pm[ow_gp_write_addr] = 1'b1;
    end

    assign ow_pending_mask = pm;

    always_ff @(posedge iw_clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (push[k]) begin
                fa[k][wp[k][PW-1:0]] <= iw_ch_addr[k*GP_AW +: GP_AW];
                fd[k][wp[k][PW-1:0]] <= iw_ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                wp[k] <= '0;
                rp[k] <= '0;
            end
            rr                 <= '0;
            ow_gp_write_enable <= 1'b0;
            ow_gp_write_addr   <= '0;
            ow_gp_write_data   <= '0;
            ow_gp_write_ch     <= '0;
            ow_retire_count    <= '0;
        end else if (iw_flush) begin
            for (int k = 0; k < N_CH; k++) begin
                wp[k] <= '0;
                rp[k] <= '0;
            end
            rr                 <= '0;
            ow_gp_write_enable <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (push[k])
                    wp[k] <= wp[k] + 1'b1;
                if (gnt_v && gnt == CW'(k))
                    rp[k] <= rp[k] + 1'b1;
            end
            ow_gp_write_enable <= gnt_v;
            if (gnt_v) begin
                rr               <= nrr;
                ow_gp_write_addr <= hd_a;
                ow_gp_write_data <= hd_d;
                ow_gp_write_ch   <= gnt;
                ow_retire_count  <= ow_retire_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stg_wb_mq.sv
// tb_stg_wb_mq: directed stimulus against a queue-based reference model of the merge stage,
// plus literal expectations for latency, fairness, back-pressure, flush, reset and wrap.
module tb_stg_wb_mq;
    localparam int N = 2, D = 4;

    logic        iw_clk = 1'b0;
    logic        iw_rst_n = 1'b1;
    logic        iw_flush = 1'b0;
    logic [1:0]  iw_ch_valid = '0;
    logic [7:0]  iw_ch_addr = '0;
    logic [47:0] iw_ch_data = '0;
    logic [1:0]  ow_ch_ready;
    logic        ow_gp_write_enable;
    logic [3:0]  ow_gp_write_addr;
    logic [23:0] ow_gp_write_data;
    logic [0:0]  ow_gp_write_ch;
    logic [15:0] ow_pending_mask;
    logic [3:0]  ow_retire_count;

    stg_wb_mq #(.N_CH(2), .DEPTH(4), .DATA_W(24), .GP_AW(4), .CNT_W(4)) dut (
        .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_flush(iw_flush),
        .iw_ch_valid(iw_ch_valid), .ow_ch_ready(ow_ch_ready),
        .iw_ch_addr(iw_ch_addr), .iw_ch_data(iw_ch_data),
        .ow_gp_write_enable(ow_gp_write_enable), .ow_gp_write_addr(ow_gp_write_addr),
        .ow_gp_write_data(ow_gp_write_data), .ow_gp_write_ch(ow_gp_write_ch),
        .ow_pending_mask(ow_pending_mask), .ow_retire_count(ow_retire_count)
    );

    always #5 iw_clk = ~iw_clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one queue of {addr,data} per channel and the port register.
    logic [27:0] mq [2][$];
    int          rr_m = 0;
    logic        m_en = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [23:0] m_data = '0;
    logic        m_ch = 1'b0;
    logic [3:0]  m_cnt = '0;
    int          log_ch [$];

    always @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            mq[0].delete(); mq[1].delete();
            rr_m = 0; m_en = 0; m_addr = 0; m_data = 0; m_ch = 0; m_cnt = 0;
        end else if (iw_flush) begin
            mq[0].delete(); mq[1].delete();
            rr_m = 0; m_en = 0;
        end else begin
            int g;
            bit acc [2];
            g = -1;
            for (int i = 0; i < N; i++)
                if (g < 0 && mq[(rr_m + i) % N].size() > 0) g = (rr_m + i) % N;
            for (int k = 0; k < N; k++)
                acc[k] = iw_ch_valid[k] && mq[k].size() < D;
            if (g >= 0) begin
                {m_addr, m_data} = mq[g].pop_front();
                m_ch = g[0]; m_en = 1; m_cnt++; rr_m = (g + 1) % N;
                log_ch.push_back(g);
            end else
                m_en = 0;
            for (int k = 0; k < N; k++)
                if (acc[k]) mq[k].push_back({iw_ch_addr[k*4 +: 4], iw_ch_data[k*24 +: 24]});
        end
    end

    function automatic logic [15:0] m_mask();
        logic [15:0] r = '0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < mq[k].size(); i++) r[mq[k][i][27:24]] = 1'b1;
        if (m_en) r[m_addr] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] m_rdy();
        logic [1:0] r;
        for (int k = 0; k < N; k++) r[k] = iw_rst_n && !iw_flush && mq[k].size() < D;
        return r;
    endfunction

    always @(negedge iw_clk) begin
        if (chk_on) begin
            chk("ready", ow_ch_ready, m_rdy());
            chk("enable", ow_gp_write_enable, m_en);
            chk("addr", ow_gp_write_addr, m_addr);
            chk("data", ow_gp_write_data, m_data);
            chk("ch", ow_gp_write_ch, m_ch);
            chk("mask", ow_pending_mask, m_mask());
            chk("count", ow_retire_count, m_cnt);
        end
    end

    task automatic nxt();
        @(negedge iw_clk);
        #1;
    endtask

    task automatic drv(logic [1:0] v, logic [3:0] a0, logic [23:0] d0, logic [3:0] a1, logic [23:0] d1);
        iw_ch_valid = v;
        iw_ch_addr  = {a1, a0};
        iw_ch_data  = {d1, d0};
    endtask

    initial begin
        int m0;
        bit saw;
        #2 iw_rst_n = 1'b0;
        repeat (2) @(negedge iw_clk);
        #1 iw_rst_n = 1'b1;
        chk_on = 1'b1;
        nxt();
        chk("rst_en", ow_gp_write_enable, 1'b0);
        chk("rst_cnt", ow_retire_count, 4'd0);
        chk("rst_mask", ow_pending_mask, 16'h0);
        chk("rst_ready", ow_ch_ready, 2'b11);

        // single-channel latency
        drv(2'b01, 4'd3, 24'h00ABCD, 4'd0, 24'd0);
        nxt();
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        chk("lat_mask_e0", ow_pending_mask, 16'h0008);
        chk("lat_en_e0", ow_gp_write_enable, 1'b0);
        nxt();
        chk("lat_en_e1", ow_gp_write_enable, 1'b1);
        chk("lat_addr_e1", ow_gp_write_addr, 4'd3);
        chk("lat_data_e1", ow_gp_write_data, 24'h00ABCD);
        chk("lat_ch_e1", ow_gp_write_ch, 1'b0);
        chk("lat_mask_e1", ow_pending_mask, 16'h0008);
        nxt();
        chk("lat_en_e2", ow_gp_write_enable, 1'b0);
        chk("lat_mask_e2", ow_pending_mask, 16'h0);
        chk("lat_cnt", ow_retire_count, 4'd1);

        // round-robin fairness from rr=0
        iw_flush = 1'b1;
        nxt();
        iw_flush = 1'b0;
        m0 = log_ch.size();
        for (int i = 0; i < 4; i++) begin
            drv(2'b11, 4'(i), 24'h100 + 24'(i), 4'(i + 4), 24'h200 + 24'(i));
            nxt();
        end
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        repeat (8) nxt();
        chk("rr_len", log_ch.size() - m0, 8);
        for (int i = 0; i < 8 && m0 + i < log_ch.size(); i++)
            chk($sformatf("rr_seq%0d", i), log_ch[m0 + i], i % 2);
        chk("rr_cnt", ow_retire_count, 4'd9);
        chk("rr_mask", ow_pending_mask, 16'h0);

        // back-pressure with both channels pushing every cycle
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drv(2'b11, 4'(8 + i % 4), 24'h700 + 24'(i), 4'(12 + i % 4), 24'h800 + 24'(i));
            nxt();
            if (!ow_ch_ready[1]) saw = 1'b1;
        end
        chk("bp_full_seen", saw, 1'b1);
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        repeat (12) nxt();
        chk("bp_drained", ow_pending_mask, 16'h0);

        // flush with 3 queued and one on the port
        drv(2'b11, 4'd1, 24'h301, 4'd2, 24'h302);
        nxt();
        drv(2'b11, 4'd5, 24'h303, 4'd6, 24'h304);
        nxt();
        chk("fl_en_pre", ow_gp_write_enable, 1'b1);
        chk("fl_mask_pre", ow_pending_mask, 16'h0066);
        iw_flush = 1'b1;
        drv(2'b11, 4'd7, 24'h305, 4'd8, 24'h306);
        #1 chk("fl_ready", ow_ch_ready, 2'b00);
        nxt();
        iw_flush = 1'b0;
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        chk("fl_en", ow_gp_write_enable, 1'b0);
        chk("fl_mask", ow_pending_mask, 16'h0);
        nxt();
        chk("fl_en2", ow_gp_write_enable, 1'b0);
        chk("fl_dropped", ow_pending_mask, 16'h0);

        // asynchronous reset between edges with entries queued
        drv(2'b11, 4'd9, 24'h401, 4'd10, 24'h402);
        nxt();
        drv(2'b11, 4'd11, 24'h403, 4'd12, 24'h404);
        nxt();
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        @(posedge iw_clk);
        #2 iw_rst_n = 1'b0;
        #1;
        chk("ar_en", ow_gp_write_enable, 1'b0);
        chk("ar_addr", ow_gp_write_addr, 4'd0);
        chk("ar_data", ow_gp_write_data, 24'd0);
        chk("ar_ch", ow_gp_write_ch, 1'b0);
        chk("ar_mask", ow_pending_mask, 16'h0);
        chk("ar_cnt", ow_retire_count, 4'd0);
        chk("ar_ready", ow_ch_ready, 2'b00);
        nxt();
        iw_rst_n = 1'b1;
        drv(2'b11, 4'd3, 24'h501, 4'd4, 24'h502);
        nxt();
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        nxt();
        chk("ar_first_en", ow_gp_write_enable, 1'b1);
        chk("ar_first_ch", ow_gp_write_ch, 1'b0);
        chk("ar_first_data", ow_gp_write_data, 24'h501);
        nxt();
        chk("ar_second_ch", ow_gp_write_ch, 1'b1);
        chk("ar_cnt2", ow_retire_count, 4'd2);

        // counter wrap: 17 retirements since reset
        for (int i = 0; i < 15; i++) begin
            drv(2'b01, 4'(i), 24'h600 + 24'(i), 4'd0, 24'd0);
            nxt();
        end
        drv(2'b00, 4'd0, 24'd0, 4'd0, 24'd0);
        repeat (4) nxt();
        chk("wrap_cnt", ow_retire_count, 4'd1);
        chk("wrap_en", ow_gp_write_enable, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
